// File: rtl/sequenciador_pkg.sv
// sequenciador_pkg
// Shared definitions for the operand sequencer: sequencer state encoding,
// default operand/result width and default watchdog limit, plus a small
// helper that tells whether a state is one of the operand-loading states.
package sequenciador_pkg;

    localparam int WIDTH_PADRAO   = 16;
    localparam int TIMEOUT_PADRAO = 64;

    typedef enum logic [2:0] {
        CARGA_X = 3'd0,
        CARGA_A = 3'd1,
        CARGA_B = 3'd2,
        CARGA_C = 3'd3,
        DISPARO = 3'd4,
        ESPERA  = 3'd5,
        ENTREGA = 3'd6
    } estado_t;

    // True in the four states where an operand word may be accepted.
    function automatic logic eh_carga(input estado_t s);
        return (s == CARGA_X) || (s == CARGA_A) || (s == CARGA_B) || (s == CARGA_C);
    endfunction

endpackage

// File: rtl/sequenciador_entrada_if.sv
// sequenciador_entrada_if
// Bundles every non-clock signal of the operand sequencer.
//   master : sequencer view (drives dado_pronto, X/A/B/C, inicio, saida*,
//            ocupado, erro_timeout; receives the input stream, datapath
//            status and downstream accept).
//   slave  : environment view (mirror of master).
// Parameter WIDTH: operand/result width.
interface sequenciador_entrada_if
    import sequenciador_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO
);
    logic [WIDTH-1:0] dado_in;
    logic             dado_valido;
    logic             dado_pronto;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             inicio;
    logic             pronto;
    logic             overflow;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] saida;
    logic             saida_ovf;
    logic             saida_valida;
    logic             saida_aceita;
    logic             ocupado;
    logic             erro_timeout;

    modport master (
        input  dado_in, dado_valido, pronto, overflow, resultado, saida_aceita,
        output dado_pronto, X, A, B, C, inicio, saida, saida_ovf, saida_valida,
               ocupado, erro_timeout
    );

    modport slave (
        output dado_in, dado_valido, pronto, overflow, resultado, saida_aceita,
        input  dado_pronto, X, A, B, C, inicio, saida, saida_ovf, saida_valida,
               ocupado, erro_timeout
    );

endinterface

// File: rtl/sequenciador_entrada_contador_timeout.sv
// contador_timeout
// Watchdog counter for the wait state. Counts up while enabled, holds at the
// limit, and returns to zero whenever clear is high.
// Ports: ck (clock), rst (sync active-high reset), clear, enable,
//        expira (count has reached TIMEOUT-1).
// Parameter TIMEOUT: number of counted cycles before expira (>= 2).
module contador_timeout
    import sequenciador_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_PADRAO
) (
    input  logic ck,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expira
);

    localparam int            CW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: clear dominates, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CW{1'b0}};
        end else if (enable && (cnt_q != LIMITE)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge ck) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expira = (cnt_q == LIMITE);

endmodule

// File: rtl/sequenciador_entrada.sv
// sequenciador_entrada
// Upstream operand sequencer for the polynomial datapath. Collects X, A, B, C
// from a serial valid/ready word stream, holds them for the datapath, pulses
// inicio, waits for the rising edge of pronto (with a watchdog), and offers the
// captured result downstream on a valid/ready handshake.
// Ports: ck (clock), rst (sync active-high reset), bus (sequenciador_entrada_if
//        master modport: input stream, datapath operands/status, result).
// Parameters: WIDTH (operand width), TIMEOUT (max cycles in ESPERA).
// Optional build macro SATURA_EN: a completion with overflow captures all ones.
module sequenciador_entrada
    import sequenciador_pkg::*;
#(
    parameter int WIDTH   = WIDTH_PADRAO,
    parameter int TIMEOUT = TIMEOUT_PADRAO
) (
    input  logic                   ck,
    input  logic                   rst,
    sequenciador_entrada_if.master bus
);

    estado_t          state_d, state_q;
    logic [WIDTH-1:0] x_d, x_q, a_d, a_q, b_d, b_q, c_d, c_q;
    logic [WIDTH-1:0] saida_d, saida_q;
    logic             saida_ovf_d, saida_ovf_q;
    logic             saida_valida_d, saida_valida_q;
    logic             erro_timeout_d, erro_timeout_q;
    logic             inicio_d, inicio_q;
    logic             ocupado_d, ocupado_q;
    logic             pronto_q;
    logic             dado_pronto_s;
    logic             transfere_s;
    logic             borda_pronto_s;
    logic             cnt_clear_s, cnt_enable_s, expira_s;

    assign dado_pronto_s  = eh_carga(state_q);
    assign transfere_s    = bus.dado_valido && dado_pronto_s;
    // Only a fresh rising edge counts, so a level left high by a previous run is ignored.
    assign borda_pronto_s = bus.pronto && !pronto_q;

    contador_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .ck     (ck),
        .rst    (rst),
        .clear  (cnt_clear_s),
        .enable (cnt_enable_s),
        .expira (expira_s)
    );

    // Next-state, operand capture, result capture and watchdog control.
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        saida_d        = saida_q;
        saida_ovf_d    = saida_ovf_q;
        saida_valida_d = saida_valida_q;
        erro_timeout_d = erro_timeout_q;
        cnt_clear_s    = 1'b1;
        cnt_enable_s   = 1'b0;
        case (state_q)
            CARGA_X: begin
                if (transfere_s) begin
                    x_d     = bus.dado_in;
                    state_d = CARGA_A;
                end else begin
                    state_d = CARGA_X;
                end
            end
            CARGA_A: begin
                if (transfere_s) begin
                    a_d     = bus.dado_in;
                    state_d = CARGA_B;
                end else begin
                    state_d = CARGA_A;
                end
            end
            CARGA_B: begin
                if (transfere_s) begin
                    b_d     = bus.dado_in;
                    state_d = CARGA_C;
                end else begin
                    state_d = CARGA_B;
                end
            end
            CARGA_C: begin
                if (transfere_s) begin
                    c_d     = bus.dado_in;
                    state_d = DISPARO;
                end else begin
                    state_d = CARGA_C;
                end
            end
            DISPARO: begin
                state_d = ESPERA;
            end
            ESPERA: begin
                cnt_clear_s  = 1'b0;
                cnt_enable_s = 1'b1;
                // Completion is tested first so it wins over a simultaneous timeout.
                if (borda_pronto_s) begin
`ifdef SATURA_EN
                    saida_d = bus.overflow ? {WIDTH{1'b1}} : bus.resultado;
`else
                    saida_d = bus.resultado;
`endif
                    saida_ovf_d    = bus.overflow;
                    saida_valida_d = 1'b1;
                    state_d        = ENTREGA;
                end else if (expira_s) begin
                    saida_d        = {WIDTH{1'b0}};
                    saida_ovf_d    = 1'b1;
                    erro_timeout_d = 1'b1;
                    saida_valida_d = 1'b1;
                    state_d        = ENTREGA;
                end else begin
                    state_d = ESPERA;
                end
            end
            ENTREGA: begin
                if (saida_valida_q && bus.saida_aceita) begin
                    saida_valida_d = 1'b0;
                    state_d        = CARGA_X;
                end else begin
                    state_d = ENTREGA;
                end
            end
            default: begin
                state_d = CARGA_X;
            end
        endcase
        // Registered from the next state so both are aligned with state_q.
        inicio_d  = (state_d == DISPARO);
        ocupado_d = (state_d != CARGA_X);
    end

    // State, operand, result and flag registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q        <= CARGA_X;
            x_q            <= {WIDTH{1'b0}};
            a_q            <= {WIDTH{1'b0}};
            b_q            <= {WIDTH{1'b0}};
            c_q            <= {WIDTH{1'b0}};
            saida_q        <= {WIDTH{1'b0}};
            saida_ovf_q    <= 1'b0;
            saida_valida_q <= 1'b0;
            erro_timeout_q <= 1'b0;
            inicio_q       <= 1'b0;
            ocupado_q      <= 1'b0;
            pronto_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            a_q            <= a_d;
            b_q            <= b_d;
            c_q            <= c_d;
            saida_q        <= saida_d;
            saida_ovf_q    <= saida_ovf_d;
            saida_valida_q <= saida_valida_d;
            erro_timeout_q <= erro_timeout_d;
            inicio_q       <= inicio_d;
            ocupado_q      <= ocupado_d;
            pronto_q       <= bus.pronto;
        end
    end

    assign bus.dado_pronto  = dado_pronto_s;
    assign bus.X            = x_q;
    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.C            = c_q;
    assign bus.inicio       = inicio_q;
    assign bus.saida        = saida_q;
    assign bus.saida_ovf    = saida_ovf_q;
    assign bus.saida_valida = saida_valida_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.erro_timeout = erro_timeout_q;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// tb_sequenciador_entrada
// Self-checking bench for sequenciador_entrada: directed scenarios (nominal,
// gapped input, backpressure, overflow, timeout with stale pronto, reset in
// ESPERA) followed by randomized runs. Expected values come from the operand
// words sent and the result/overflow the bench's datapath model returns.
module tb_sequenciador_entrada;

    localparam int W  = 16;
    localparam int TO = 64;

    logic ck = 1'b0;
    logic rst;

    always #5 ck = ~ck;

    sequenciador_entrada_if #(.WIDTH(W)) bus ();

    sequenciador_entrada #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] pal [4];
    logic         erro_esp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ciclo();
        @(posedge ck);
        #1;
    endtask

    function automatic logic [W-1:0] operando(input int k);
        case (k)
            0:       return bus.X;
            1:       return bus.A;
            2:       return bus.B;
            default: return bus.C;
        endcase
    endfunction

    // Result the downstream side must see for a completed computation.
    function automatic logic [W-1:0] esperado(input logic [W-1:0] r, input logic o);
`ifdef SATURA_EN
        return o ? 16'hFFFF : r;
`else
        return r;
`endif
    endfunction

    // Streams pal[0..3] with gk idle cycles before word k; ends in the inicio cycle.
    task automatic carrega(input int g0, input int g1, input int g2, input int g3, input bit segura);
        int gaps [4];
        gaps = '{g0, g1, g2, g3};
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                bus.dado_valido = 1'b0;
                bus.dado_in     = W'($urandom);
                chk("pronto_em_carga", 32'(bus.dado_pronto), 32'd1);
                ciclo();
                chk("inicio_prematuro", 32'(bus.inicio), 32'd0);
            end
            bus.dado_valido = 1'b1;
            bus.dado_in     = pal[k];
            chk("pronto_em_carga", 32'(bus.dado_pronto), 32'd1);
            ciclo();
            chk($sformatf("operando_%0d", k), 32'(operando(k)), 32'(pal[k]));
            if (k < 3) chk("inicio_prematuro", 32'(bus.inicio), 32'd0);
            else       chk("inicio_apos_c", 32'(bus.inicio), 32'd1);
        end
        bus.dado_valido = segura;
        bus.dado_in     = W'($urandom);
        chk("pronto_disparo", 32'(bus.dado_pronto), 32'd0);
        chk("ocupado_disparo", 32'(bus.ocupado), 32'd1);
    endtask

    // Datapath model: pronto rises lat cycles after the inicio cycle.
    task automatic espera_dp(input int lat, input logic [W-1:0] res, input logic ovf);
        bus.pronto = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            ciclo();
            chk("inicio_um_ciclo", 32'(bus.inicio), 32'd0);
            chk("valida_cedo", 32'(bus.saida_valida), 32'd0);
            chk("pronto_espera", 32'(bus.dado_pronto), 32'd0);
            chk("X_estavel", 32'(bus.X), 32'(pal[0]));
            chk("C_estavel", 32'(bus.C), 32'(pal[3]));
        end
        bus.pronto    = 1'b1;
        bus.resultado = res;
        bus.overflow  = ovf;
        ciclo();
        chk("valida_sobe", 32'(bus.saida_valida), 32'd1);
        chk("saida", 32'(bus.saida), 32'(esperado(res, ovf)));
        chk("saida_ovf", 32'(bus.saida_ovf), 32'(ovf));
        chk("erro_timeout", 32'(bus.erro_timeout), 32'(erro_esp));
        bus.resultado = W'($urandom);
        bus.overflow  = 1'($urandom);
    endtask

    // pronto is left high; the watchdog must fire after TO cycles in ESPERA.
    task automatic espera_timeout();
        for (int c = 1; c <= TO; c++) begin
            bus.resultado = W'($urandom);
            bus.overflow  = 1'($urandom);
            ciclo();
            chk("valida_antes_timeout", 32'(bus.saida_valida), 32'd0);
        end
        ciclo();
        erro_esp = 1'b1;
        chk("valida_timeout", 32'(bus.saida_valida), 32'd1);
        chk("saida_timeout", 32'(bus.saida), 32'd0);
        chk("ovf_timeout", 32'(bus.saida_ovf), 32'd1);
        chk("erro_timeout", 32'(bus.erro_timeout), 32'd1);
    endtask

    // Holds off the accept for bp cycles, then accepts once.
    task automatic entrega(input int bp, input logic [W-1:0] s_esp, input logic o_esp);
        for (int i = 0; i < bp; i++) begin
            bus.saida_aceita = 1'b0;
            bus.resultado    = W'($urandom);
            ciclo();
            chk("saida_retida", 32'(bus.saida), 32'(s_esp));
            chk("ovf_retido", 32'(bus.saida_ovf), 32'(o_esp));
            chk("valida_retida", 32'(bus.saida_valida), 32'd1);
            chk("pronto_entrega", 32'(bus.dado_pronto), 32'd0);
        end
        bus.saida_aceita = 1'b1;
        ciclo();
        bus.dado_valido = 1'b0;
        chk("valida_desce", 32'(bus.saida_valida), 32'd0);
        chk("ocupado_volta", 32'(bus.ocupado), 32'd0);
        chk("pronto_volta", 32'(bus.dado_pronto), 32'd1);
        chk("erro_sticky", 32'(bus.erro_timeout), 32'(erro_esp));
    endtask

    task automatic run_normal(input int g0, input int g1, input int g2, input int g3, input bit segura,
                              input int lat, input logic [W-1:0] res, input logic ovf, input int bp);
        carrega(g0, g1, g2, g3, segura);
        espera_dp(lat, res, ovf);
        entrega(bp, esperado(res, ovf), ovf);
    endtask

    task automatic palavras_aleatorias();
        for (int k = 0; k < 4; k++) pal[k] = W'($urandom);
    endtask

    initial begin
        rst              = 1'b1;
        bus.dado_in      = '0;
        bus.dado_valido  = 1'b0;
        bus.pronto       = 1'b0;
        bus.overflow     = 1'b0;
        bus.resultado    = '0;
        bus.saida_aceita = 1'b1;
        ciclo();
        ciclo();
        chk("rst_X", 32'(bus.X), 32'd0);
        chk("rst_C", 32'(bus.C), 32'd0);
        chk("rst_saida", 32'(bus.saida), 32'd0);
        chk("rst_inicio", 32'(bus.inicio), 32'd0);
        chk("rst_valida", 32'(bus.saida_valida), 32'd0);
        chk("rst_ovf", 32'(bus.saida_ovf), 32'd0);
        chk("rst_erro", 32'(bus.erro_timeout), 32'd0);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_dado_pronto", 32'(bus.dado_pronto), 32'd1);
        rst = 1'b0;

        // Nominal run, valid held high.
        pal = '{16'd23, 16'd38, 16'd333, 16'd4902};
        run_normal(0, 0, 0, 0, 1'b1, 5, 16'h7F97, 1'b0, 0);

        // Gapped input: valid pattern 1-0-0-1-0-1-1.
        palavras_aleatorias();
        run_normal(0, 2, 1, 0, 1'b0, 7, W'($urandom), 1'b0, 0);

        // Backpressure for 10 cycles.
        palavras_aleatorias();
        run_normal(1, 0, 2, 0, 1'b0, 4, W'($urandom), 1'b0, 10);

        // Overflow from the datapath.
        palavras_aleatorias();
        run_normal(0, 0, 0, 0, 1'b0, 3, 16'h1234, 1'b1, 2);

        // Timeout with pronto stale-high from before DISPARO.
        palavras_aleatorias();
        bus.pronto = 1'b1;
        carrega(0, 1, 0, 0, 1'b0);
        espera_timeout();
        entrega(3, 16'h0000, 1'b1);

        // Normal runs afterwards keep erro_timeout set.
        for (int r = 0; r < 6; r++) begin
            palavras_aleatorias();
            run_normal($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom), $urandom_range(1, 20),
                       W'($urandom), 1'($urandom), $urandom_range(0, 4));
        end

        // Reset while in ESPERA.
        palavras_aleatorias();
        carrega(0, 0, 0, 0, 1'b0);
        bus.pronto = 1'b0;
        ciclo();
        ciclo();
        ciclo();
        rst = 1'b1;
        ciclo();
        rst      = 1'b0;
        erro_esp = 1'b0;
        chk("rstmeio_X", 32'(bus.X), 32'd0);
        chk("rstmeio_A", 32'(bus.A), 32'd0);
        chk("rstmeio_B", 32'(bus.B), 32'd0);
        chk("rstmeio_C", 32'(bus.C), 32'd0);
        chk("rstmeio_saida", 32'(bus.saida), 32'd0);
        chk("rstmeio_ovf", 32'(bus.saida_ovf), 32'd0);
        chk("rstmeio_valida", 32'(bus.saida_valida), 32'd0);
        chk("rstmeio_inicio", 32'(bus.inicio), 32'd0);
        chk("rstmeio_erro", 32'(bus.erro_timeout), 32'd0);
        chk("rstmeio_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rstmeio_dado_pronto", 32'(bus.dado_pronto), 32'd1);
        bus.pronto = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ciclo();
            chk("rstmeio_sem_valida", 32'(bus.saida_valida), 32'd0);
            chk("rstmeio_sem_inicio", 32'(bus.inicio), 32'd0);
        end

        // Fresh run after reset starts from CARGA_X.
        palavras_aleatorias();
        run_normal(0, 1, 0, 2, 1'b0, 6, W'($urandom), 1'b1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
